// File: rtl/mem_map_pkg.sv
// Memory map constants, DMA state encoding and an address-range helper shared by
// the copy engine and the CPU store-fault logic.
package mem_map_pkg;

   localparam logic [7:0] ROM_BASE  = 8'h00;
   localparam logic [7:0] ROM_END   = 8'h7F;
   localparam logic [7:0] RW_BASE   = 8'h80;
   localparam logic [7:0] RW_END    = 8'hDF;
   localparam logic [7:0] PORT_BASE = 8'hF0;
   localparam logic [7:0] PORT_END  = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR      = 3'd3,
      ST_DONE    = 3'd4
   } dma_state_e;

   // Offset compare keeps the test free of always-true bounds at 0x00 / 0xFF.
   function automatic logic in_range(logic [7:0] a, logic [7:0] lo, logic [7:0] hi);
      return (8'(a - lo) <= 8'(hi - lo));
   endfunction

endpackage

// File: rtl/mem_copy_dma8_if.sv
// Control and memory-bus signals of the byte-copy DMA; master is the DMA side,
// slave is the system side (bus mux, memory and requester).
interface mem_copy_dma8_if;
   import mem_map_pkg::*;

   // start is a one-cycle request honoured only while busy is low; each accepted
   // start is answered by exactly one done pulse unless reset intervenes.
   logic       start;
   logic [7:0] src_addr;
   logic [7:0] dst_addr;
   logic [7:0] length;
   logic [7:0] mem_data_in;
   logic [7:0] mem_address;
   logic [7:0] mem_data_out;
   logic       mem_write;
   logic       busy;
   logic       done;
   logic       error;
   dma_state_e dbg_state;

   modport master (
      input  start, src_addr, dst_addr, length, mem_data_in,
      output mem_address, mem_data_out, mem_write, busy, done, error, dbg_state
   );

   modport slave (
      output start, src_addr, dst_addr, length, mem_data_in,
      input  mem_address, mem_data_out, mem_write, busy, done, error, dbg_state
   );

endinterface

// File: rtl/mem_map_writable.sv
// Combinational decode: high when the address is a legal store target (RW RAM or ports).
module mem_map_writable
   import mem_map_pkg::*;
(
   input  logic [7:0] addr,
   output logic       writable
);

   assign writable = in_range(addr, RW_BASE, RW_END) || in_range(addr, PORT_BASE, PORT_END);

endmodule

// File: rtl/mem_copy_dma8.sv
// Byte-copy bus master: read src_ptr, wait READ_WAIT cycles, write dst_ptr, repeat
// until count is exhausted or the destination falls outside writable memory.
module mem_copy_dma8
   import mem_map_pkg::*;
#(
   parameter int READ_WAIT = 1
) (
   input  logic            clk,
   input  logic            reset,
   mem_copy_dma8_if.master bus
);

   dma_state_e state_q, state_d;
   logic [7:0] src_ptr_q, src_ptr_d;
   logic [7:0] dst_ptr_q, dst_ptr_d;
   logic [7:0] count_q, count_d;
   logic [1:0] wait_q, wait_d;
   logic [7:0] data_q, data_d;
   logic       error_q, error_d;

   logic [7:0] mem_address_c;
   logic [7:0] mem_data_out_c;
   logic       mem_write_c;
   logic       dst_writable;

   mem_map_writable u_dst_check (
      .addr     (dst_ptr_q),
      .writable (dst_writable)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         src_ptr_q <= 8'h00;
         dst_ptr_q <= 8'h00;
         count_q   <= 8'h00;
         wait_q    <= 2'd0;
         data_q    <= 8'h00;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_ptr_q <= src_ptr_d;
         dst_ptr_q <= dst_ptr_d;
         count_q   <= count_d;
         wait_q    <= wait_d;
         data_q    <= data_d;
         error_q   <= error_d;
      end
   end

   // Bus outputs decode from registered state only; idle bus reads as all zero.
   always_comb begin
      state_d        = state_q;
      src_ptr_d      = src_ptr_q;
      dst_ptr_d      = dst_ptr_q;
      count_d        = count_q;
      wait_d         = wait_q;
      data_d         = data_q;
      error_d        = error_q;
      mem_address_c  = 8'h00;
      mem_data_out_c = 8'h00;
      mem_write_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               src_ptr_d = bus.src_addr;
               dst_ptr_d = bus.dst_addr;
               count_d   = bus.length;
               error_d   = 1'b0;
               state_d   = (bus.length == 8'h00) ? ST_DONE : ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            mem_address_c = src_ptr_q;
            wait_d        = 2'(READ_WAIT - 1);
            state_d       = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            mem_address_c = src_ptr_q;
            if (wait_q == 2'd0) begin
               data_d  = bus.mem_data_in;
               state_d = ST_WR;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_WR: begin
            if (dst_writable) begin
               mem_address_c  = dst_ptr_q;
               mem_data_out_c = data_q;
               mem_write_c    = 1'b1;
               src_ptr_d      = src_ptr_q + 8'd1;
               dst_ptr_d      = dst_ptr_q + 8'd1;
               count_d        = count_q - 8'd1;
               state_d        = (count_q == 8'd1) ? ST_DONE : ST_RD_ADDR;
            end else begin
               error_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.mem_address  = mem_address_c;
   assign bus.mem_data_out = mem_data_out_c;
   assign bus.mem_write    = mem_write_c;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = (state_q == ST_DONE);
   assign bus.error        = error_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_mem_copy_dma8.sv
// Bench for mem_copy_dma8: behavioural memory on the bus, directed copy jobs,
// and a monitor that pops expected writes and done pulses from queues.
module tb_mem_copy_dma8;

   logic clk = 1'b0;
   logic reset;

   mem_copy_dma8_if bus ();

   mem_copy_dma8 #(.READ_WAIT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [256];
   logic [7:0]  rd_q;
   logic [15:0] exp_q [$];
   logic [0:0]  exp_done_q [$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic tb_writable(logic [7:0] a);
      return ((a >= 8'h80) && (a <= 8'hDF)) || (a >= 8'hF0);
   endfunction

   // Synchronous-read memory: data for the address of cycle k appears in cycle k+1.
   always @(posedge clk) begin
      rd_q <= mem[bus.mem_address];
      if (bus.mem_write && tb_writable(bus.mem_address))
         mem[bus.mem_address] <= bus.mem_data_out;
   end
   assign bus.mem_data_in = rd_q;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write and every done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (bus.mem_write) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {bus.mem_address, bus.mem_data_out}, 16'hxxxx);
         end else begin
            check("write_addr_data", {bus.mem_address, bus.mem_data_out}, exp_q.pop_front());
         end
      end
      if (bus.done) begin
         check("done_with_busy", {15'd0, bus.busy}, 16'd1);
         if (exp_done_q.size() == 0) begin
            check("unexpected_done", 16'd1, 16'd0);
         end else begin
            check("done_error", {15'd0, bus.error}, {15'd0, exp_done_q.pop_front()});
         end
      end
   end

   task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input int exp_busy, input int inject_at);
      int n;
      bus.start    = 1'b1;
      bus.src_addr = s;
      bus.dst_addr = d;
      bus.length   = l;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.src_addr = 8'h55;
      bus.dst_addr = 8'h55;
      bus.length   = 8'h55;
      check("error_cleared_on_start", {15'd0, bus.error}, 16'd0);
      n = 0;
      while (bus.busy && n < 300) begin
         n++;
         if (n == inject_at) begin
            bus.start    = 1'b1;
            bus.src_addr = 8'h00;
            bus.dst_addr = 8'hD0;
            bus.length   = 8'h09;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("busy_cycles", 16'(n), 16'(exp_busy));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         if (i < 8'h80)       mem[i] <= 8'(i) ^ 8'h5A;
         else if (i < 8'hE0)  mem[i] <= 8'h00;
         else if (i < 8'hF0)  mem[i] <= 8'hFF;
         else                 mem[i] <= 8'h00;
      end
      @(negedge clk);
      mem[8'h00] <= 8'hA5;
      mem[8'h80] <= 8'h11;
      mem[8'h81] <= 8'h22;
      mem[8'h82] <= 8'h33;
      mem[8'h83] <= 8'h44;
   end

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.src_addr = 8'h00;
      bus.dst_addr = 8'h00;
      bus.length   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_address",  {8'h00, bus.mem_address}, 16'h0000);
      check("rst_data_out", {8'h00, bus.mem_data_out}, 16'h0000);
      check("rst_ctrl", {12'd0, bus.mem_write, bus.busy, bus.done, bus.error}, 16'h0000);
      reset = 1'b0;
      @(negedge clk);

      // RAM to RAM, four bytes.
      exp_q.push_back(16'h9011); exp_q.push_back(16'h9122);
      exp_q.push_back(16'h9233); exp_q.push_back(16'h9344);
      exp_done_q.push_back(1'b0);
      run_copy(8'h80, 8'h90, 8'd4, 13, 0);
      check("mem_90", {8'h00, mem[8'h90]}, 16'h0011);
      check("mem_93", {8'h00, mem[8'h93]}, 16'h0044);

      // ROM to port.
      exp_q.push_back(16'hF0A5);
      exp_done_q.push_back(1'b0);
      run_copy(8'h00, 8'hF0, 8'd1, 4, 0);
      check("port_f0", {8'h00, mem[8'hF0]}, 16'h00A5);

      // Destination in ROM: first write faults.
      exp_done_q.push_back(1'b1);
      run_copy(8'h80, 8'h7E, 8'd3, 4, 0);
      check("error_sticky", {15'd0, bus.error}, 16'd1);
      check("rom_7e_untouched", {8'h00, mem[8'h7E]}, 16'h0024);

      // A valid copy clears the sticky error.
      exp_q.push_back(16'hC011);
      exp_done_q.push_back(1'b0);
      run_copy(8'h80, 8'hC0, 8'd1, 4, 0);
      check("error_after_valid", {15'd0, bus.error}, 16'd0);

      // Destination wraps from 0xFF into ROM at 0x00.
      exp_q.push_back(16'hFE11); exp_q.push_back(16'hFF22);
      exp_done_q.push_back(1'b1);
      run_copy(8'h80, 8'hFE, 8'd4, 10, 0);
      check("wrap_error", {15'd0, bus.error}, 16'd1);
      check("wrap_mem_ff", {8'h00, mem[8'hFF]}, 16'h0022);
      check("wrap_mem_00", {8'h00, mem[8'h00]}, 16'h00A5);

      // Zero length: single DONE cycle, no bus traffic.
      exp_done_q.push_back(1'b0);
      run_copy(8'h10, 8'hA0, 8'd0, 1, 0);
      check("zero_len_error", {15'd0, bus.error}, 16'd0);

      // Second start mid-transfer is ignored.
      exp_q.push_back(16'hB011); exp_q.push_back(16'hB122);
      exp_q.push_back(16'hB233); exp_q.push_back(16'hB344);
      exp_done_q.push_back(1'b0);
      run_copy(8'h80, 8'hB0, 8'd4, 13, 3);
      check("ignored_start_d0", {8'h00, mem[8'hD0]}, 16'h0000);
      check("busy_start_b3", {8'h00, mem[8'hB3]}, 16'h0044);

      // Reset asserted during the WR cycle of byte 2 of 4.
      exp_q.push_back(16'hA011); exp_q.push_back(16'hA122);
      bus.start    = 1'b1;
      bus.src_addr = 8'h80;
      bus.dst_addr = 8'hA0;
      bus.length   = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      check("wr_before_reset", {15'd0, bus.mem_write}, 16'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_address",  {8'h00, bus.mem_address}, 16'h0000);
      check("abort_data_out", {8'h00, bus.mem_data_out}, 16'h0000);
      check("abort_ctrl", {12'd0, bus.mem_write, bus.busy, bus.done, bus.error}, 16'h0000);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_idle_busy", {15'd0, bus.busy}, 16'd0);
      check("abort_mem_a1", {8'h00, mem[8'hA1]}, 16'h0022);
      check("abort_mem_a2", {8'h00, mem[8'hA2]}, 16'h0000);

      check("writes_left", 16'(exp_q.size()), 16'd0);
      check("dones_left", 16'(exp_done_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_copy_dma8.md
# mem_copy_dma8

Bus-master block that copies a run of bytes from one 8-bit address to another across the computer's memory bus: ROM 0x00–0x7F, RW 0x80–0xDF, ports 0xF0–0xFF. It is the initiator side of the memory interface. It drives `address`, write data and `write`, and reads back the memory's data bus. It sits beside the CPU, behind a bus-ownership mux that grants the bus while `busy` is high.

## Interface
Parameters:
- READ_WAIT, default 1: cycles between presenting a read address and sampling read data. Matches the synchronous ROM/RW read latency. Legal range 1–3.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  8  first source address; captured on accepted start
- dst_addr  in  8  first destination address; captured on accepted start
- length  in  8  byte count, 0–255; captured on accepted start
- mem_data_in  in  8  memory read data (memory `data_out`)
- mem_address  out  8  bus address
- mem_data_out  out  8  bus write data (memory `data_in`)
- mem_write  out  1  bus write strobe, one cycle per byte
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse on completion or abort
- error  out  1  sticky abort flag; cleared on next accepted start or reset

One clock; reset is synchronous and active-high.

## Operation
States: IDLE, RD_ADDR, RD_WAIT, WR, DONE.
- **IDLE**
  - On `start`: latch src, dst and length into src_ptr, dst_ptr and count; clear error.
  - If count==0, go to DONE. Otherwise go to RD_ADDR.
- **RD_ADDR**
  - Drive mem_address=src_ptr with mem_write=0.
  - Go to RD_WAIT and load wait counter = READ_WAIT-1.
- **RD_WAIT**
  - Hold mem_address=src_ptr.
  - When the wait counter reaches 0, capture mem_data_in into data_reg and go to WR.
- **WR**
  - Check dst_ptr against the memory map.
  - If dst_ptr is writable (0x80–0xDF or 0xF0–0xFF): drive mem_address=dst_ptr, mem_data_out=data_reg, mem_write=1. Then increment src_ptr and dst_ptr (mod 256) and decrement count. If the new count is 0, go to DONE; otherwise go to RD_ADDR.
  - If dst_ptr is not writable (0x00–0x7F or 0xE0–0xEF): keep mem_write=0, set error and go to DONE. Bytes already written stay written.
- **DONE**
  - Assert done for one cycle, then go to IDLE.
- Source reads may come from any address. Reading an unmapped source (0xE0–0xEF) copies whatever the bus returns; this is not an error.
- Pointer wrap: 0xFF+1 = 0x00, silently, with no error on wrap itself. The destination check still applies after the wrap.
- `start` asserted while busy is ignored and has no side effects.

## Timing
- Reset values: mem_address=0x00, mem_data_out=0x00, mem_write=0, busy=0, done=0, error=0. State returns to IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- Start accepted at edge E: busy is high from E; the first RD_ADDR is the cycle after E.
- Per byte: 2+READ_WAIT cycles, which is 3 at the default.
  - Total for length N>0 is N·(2+READ_WAIT)+1 cycles, including DONE.
  - length=0 takes 1 cycle in DONE, with no bus activity.
- mem_write is high for exactly one cycle per byte and never in RD_ADDR or RD_WAIT.
- done and busy are high together in the DONE cycle. busy drops the following cycle.
- Reset mid-transfer aborts on the same edge:
  - mem_write=0 that cycle, no done pulse, error=0.
  - A partially completed copy is not rolled back.
- start and reset together: reset wins.

## Structure
- Package `mem_map_pkg` holds:
  - Constants ROM_BASE=0x00, ROM_END=0x7F, RW_BASE=0x80, RW_END=0xDF, PORT_BASE=0xF0, PORT_END=0xFF.
  - The state encoding for IDLE, RD_ADDR, RD_WAIT, WR and DONE.
- Sub-module `mem_map_writable`: combinational; input 8-bit addr, output 1-bit writable. It is reused later by the CPU store-fault logic.
- The top level holds the FSM, pointers, count, wait counter and data_reg.

## Test plan
- **RAM→RAM copy.** Preload 0x80–0x83 = 11,22,33,44; start src=0x80, dst=0x90, len=4. Expect 0x90–0x93 = 11,22,33,44, busy for 13 cycles, one done pulse, error=0.
- **ROM→port copy.** Start src=0x00, dst=0xF0, len=1, ROM[0]=0xA5. Expect port_out_00=0xA5 and exactly one mem_write pulse with mem_address=0xF0.
- **Destination fault.** Start dst=0x7E, len=3. Expect no mem_write, error=1, done after 3 cycles of bus activity. A second start with a valid dst clears error.
- **Wrap into fault.** Start src=0x80, dst=0xFE, len=4. Expect writes to 0xFE and 0xFF. dst then wraps to 0x00, so expect error=1, count stopped at 2, and 0x00 never written.
- **Zero length and start-while-busy.** len=0 gives done one cycle after start with no bus cycles. A second start pulsed mid-transfer does not alter the pointers or the final memory contents.
- **Reset mid-copy.** Assert reset during the WR cycle of byte 2 of 4. Expect all outputs at reset values next cycle, no done pulse, and only byte 1 (plus byte 2 if its write edge coincided with reset's) in memory.
